pcs_rx_decoder: RTL and testbench

//  Receive-side 64b/66b PCS: counterpart of the TX PCS encoder. Takes 66-bit blocks from the gearbox.

---
 rtl/pcs_rx_decoder.sv | 353 +++++++++++++++++++++++++++++++++++
 tb/tb_pcs_rx_decoder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_rx_decoder.sv
// pcs_rx_decoder: receive-side 64b/66b PCS decoder.
//
// Acquires block lock on the 2-bit sync header and pulses slip to the gearbox while searching.
// Once locked, it decodes each 66-bit block into 8 lanes of RXD/RXC for the reconciliation
// sublayer and checks start/terminate sequencing. Output latency is one cycle.
//
// Optional feature: define PCS_BER_MON_EN to build the high-BER monitor. Without it, hi_ber
// is tied low.
//
// Ports:
//   rx_clk          receive clock, rising edge
//   rx_rst_n        asynchronous active-low reset
//   rx_block        [1:0] sync header, [9:2] block type field, [65:10] payload
//   rx_block_valid  rx_block qualifier
//   rxd / rxc       decoded octets and per-lane control flags (lane k = rxd[8k+:8], rxc[k])
//   rx_valid        rxd/rxc updated this cycle
//   block_lock      sync-header lock achieved
//   slip            one-cycle request to shift gearbox alignment by one bit
//   hi_ber          high bit-error-rate flag
//   dec_err_cnt     saturating count of blocks decoded as error while locked
module pcs_rx_decoder #(
  parameter int unsigned SH_LOCK_CNT    = 64,
  parameter int unsigned SH_INVALID_MAX = 16,
  parameter int unsigned SLIP_WAIT      = 4,
  parameter int unsigned ERR_CNT_WIDTH  = 16,
  parameter int unsigned BER_WINDOW     = 1250,
  parameter int unsigned BER_THRESH     = 16
) (
  input  logic                     rx_clk,
  input  logic                     rx_rst_n,
  input  logic [65:0]              rx_block,
  input  logic                     rx_block_valid,
  output logic [63:0]              rxd,
  output logic [7:0]               rxc,
  output logic                     rx_valid,
  output logic                     block_lock,
  output logic                     slip,
  output logic                     hi_ber,
  output logic [ERR_CNT_WIDTH-1:0] dec_err_cnt
);

  localparam logic [63:0] ErrRxd = {8{8'hFE}};

  localparam int unsigned ShW   = $clog2(SH_LOCK_CNT + 1);
  localparam int unsigned InvW  = $clog2(SH_INVALID_MAX + 1);
  localparam int unsigned WaitW = $clog2(SLIP_WAIT + 1);

  // Lock FSM states
  localparam logic [1:0] StUnlocked = 2'd0;
  localparam logic [1:0] StSlipHold = 2'd1;
  localparam logic [1:0] StLocked   = 2'd2;

  // Block classes produced by the decoder
  localparam logic [2:0] KErr   = 3'd0;
  localparam logic [2:0] KData  = 3'd1;
  localparam logic [2:0] KCtrl  = 3'd2;
  localparam logic [2:0] KStart = 3'd3;
  localparam logic [2:0] KTerm  = 3'd4;

  logic [1:0]  hdr;
  logic [7:0]  btf;
  logic [55:0] payload;
  logic [63:0] pay_ext;
  logic        hdr_ok;

  assign hdr     = rx_block[1:0];
  assign btf     = rx_block[9:2];
  assign payload = rx_block[65:10];
  assign pay_ext = {8'h00, payload};
  assign hdr_ok  = ^hdr;

  // ---------------------------------------------------------------------------------------------
  // Block lock
  // ---------------------------------------------------------------------------------------------
  logic [1:0]       lock_st_q, lock_st_d;
  logic [ShW-1:0]   sh_cnt_q, sh_cnt_d;
  logic [InvW-1:0]  inv_cnt_q, inv_cnt_d;
  logic [5:0]       win_cnt_q, win_cnt_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             slip_q, slip_d;

  always_comb begin
    lock_st_d  = lock_st_q;
    sh_cnt_d   = sh_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    win_cnt_d  = win_cnt_q;
    wait_cnt_d = wait_cnt_q;
    slip_d     = 1'b0;
    if (rx_block_valid) begin
      case (lock_st_q)
        StUnlocked: begin
          if (hdr_ok) begin
            if (sh_cnt_q == ShW'(SH_LOCK_CNT - 1)) begin
              lock_st_d = StLocked;
              sh_cnt_d  = '0;
              inv_cnt_d = '0;
              win_cnt_d = '0;
            end else begin
              sh_cnt_d = sh_cnt_q + 1'b1;
            end
          end else begin
            slip_d     = 1'b1;
            sh_cnt_d   = '0;
            wait_cnt_d = '0;
            lock_st_d  = StSlipHold;
          end
        end
        StSlipHold: begin
          if (wait_cnt_q == WaitW'(SLIP_WAIT - 1)) begin
            wait_cnt_d = '0;
            lock_st_d  = StUnlocked;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        StLocked: begin
          // Dropping lock takes priority over the end-of-window clear.
          if (!hdr_ok && inv_cnt_q == InvW'(SH_INVALID_MAX - 1)) begin
            lock_st_d  = StSlipHold;
            slip_d     = 1'b1;
            inv_cnt_d  = '0;
            win_cnt_d  = '0;
            sh_cnt_d   = '0;
            wait_cnt_d = '0;
          end else if (win_cnt_q == 6'd63) begin
            inv_cnt_d = '0;
            win_cnt_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            if (!hdr_ok) inv_cnt_d = inv_cnt_q + 1'b1;
          end
        end
        default: lock_st_d = StUnlocked;
      endcase
    end
  end

  assign block_lock = (lock_st_q == StLocked);

  // ---------------------------------------------------------------------------------------------
  // High-BER monitor
  // ---------------------------------------------------------------------------------------------
  logic hi_ber_q;

`ifdef PCS_BER_MON_EN
  localparam int unsigned BerBlkW = $clog2(BER_WINDOW);
  localparam int unsigned BerInvW = $clog2(BER_THRESH + 1);

  logic [BerBlkW-1:0] ber_blk_q, ber_blk_d;
  logic [BerInvW-1:0] ber_inv_q, ber_inv_d, ber_inv_next;
  logic               hi_ber_d;

  always_comb begin
    ber_blk_d    = ber_blk_q;
    ber_inv_d    = ber_inv_q;
    hi_ber_d     = hi_ber_q;
    ber_inv_next = ber_inv_q;
    if (rx_block_valid && block_lock) begin
      // Saturate at the threshold; only the comparison against it matters.
      if (!hdr_ok && ber_inv_q != BerInvW'(BER_THRESH)) ber_inv_next = ber_inv_q + 1'b1;
      if (ber_inv_next >= BerInvW'(BER_THRESH)) hi_ber_d = 1'b1;
      if (ber_blk_q == BerBlkW'(BER_WINDOW - 1)) begin
        if (ber_inv_next < BerInvW'(BER_THRESH)) hi_ber_d = 1'b0;
        ber_blk_d = '0;
        ber_inv_d = '0;
      end else begin
        ber_blk_d = ber_blk_q + 1'b1;
        ber_inv_d = ber_inv_next;
      end
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      ber_blk_q <= '0;
      ber_inv_q <= '0;
      hi_ber_q  <= 1'b0;
    end else begin
      ber_blk_q <= ber_blk_d;
      ber_inv_q <= ber_inv_d;
      hi_ber_q  <= hi_ber_d;
    end
  end
`else
  logic unused_ber_cfg;
  assign unused_ber_cfg = ^{32'(BER_WINDOW), 32'(BER_THRESH)};
  assign hi_ber_q       = 1'b0;
`endif

  assign hi_ber = hi_ber_q;

  // ---------------------------------------------------------------------------------------------
  // Block decode
  // ---------------------------------------------------------------------------------------------
  logic [63:0] dec_rxd;
  logic [7:0]  dec_rxc;
  logic [2:0]  kind;
  logic [2:0]  term_n;
  logic        ctrl_ok;
  logic [6:0]  ch;

  always_comb begin
    dec_rxd = ErrRxd;
    dec_rxc = 8'hFF;
    kind    = KErr;
    term_n  = 3'd0;
    ctrl_ok = 1'b1;
    ch      = '0;
    if (hdr == 2'b10) begin
      dec_rxd = rx_block[65:2];
      dec_rxc = 8'h00;
      kind    = KData;
    end else if (hdr == 2'b01) begin
      case (btf)
        8'h1E: begin
          for (int k = 0; k < 8; k++) begin
            ch = payload[7*k+:7];
            case (ch)
              7'h00:   dec_rxd[8*k+:8] = 8'h07;
              7'h06:   dec_rxd[8*k+:8] = 8'h06;
              7'h1E:   dec_rxd[8*k+:8] = 8'hFE;
              default: ctrl_ok = 1'b0;
            endcase
          end
          if (ctrl_ok) kind = KCtrl;
          else         dec_rxd = ErrRxd;
        end
        8'h78: begin
          dec_rxd = {payload, 8'hFB};
          dec_rxc = 8'h01;
          kind    = KStart;
        end
        8'h87: begin kind = KTerm; term_n = 3'd0; end
        8'h99: begin kind = KTerm; term_n = 3'd1; end
        8'hAA: begin kind = KTerm; term_n = 3'd2; end
        8'hB4: begin kind = KTerm; term_n = 3'd3; end
        8'hCC: begin kind = KTerm; term_n = 3'd4; end
        8'hD2: begin kind = KTerm; term_n = 3'd5; end
        8'hE1: begin kind = KTerm; term_n = 3'd6; end
        8'hFF: begin kind = KTerm; term_n = 3'd7; end
        default: ;
      endcase
      if (kind == KTerm) begin
        // Lanes past the terminate become idle; the control bits carried there are ignored.
        for (int k = 0; k < 8; k++) begin
          if (3'(k) < term_n) begin
            dec_rxd[8*k+:8] = pay_ext[8*k+:8];
            dec_rxc[k]      = 1'b0;
          end else if (3'(k) == term_n) begin
            dec_rxd[8*k+:8] = 8'hFD;
            dec_rxc[k]      = 1'b1;
          end else begin
            dec_rxd[8*k+:8] = 8'h07;
            dec_rxc[k]      = 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Frame sequencing and error substitution
  // ---------------------------------------------------------------------------------------------
  logic frame_q, frame_d;
  logic out_err, count_err;

  always_comb begin
    frame_d   = frame_q;
    out_err   = 1'b0;
    count_err = 1'b0;
    if (!block_lock) begin
      frame_d = 1'b0;
      out_err = 1'b1;
    end else if (hi_ber_q) begin
      frame_d   = 1'b0;
      out_err   = 1'b1;
      count_err = 1'b1;
    end else begin
      case (kind)
        KStart: frame_d = 1'b1;
        KData: begin
          if (!frame_q) begin
            out_err   = 1'b1;
            count_err = 1'b1;
          end
        end
        KTerm: begin
          if (!frame_q) begin
            out_err   = 1'b1;
            count_err = 1'b1;
          end else begin
            frame_d = 1'b0;
          end
        end
        KCtrl: begin
          // Idle/ordered sets inside a frame mean the terminate was lost.
          if (frame_q) begin
            out_err   = 1'b1;
            count_err = 1'b1;
            frame_d   = 1'b0;
          end
        end
        default: begin
          out_err   = 1'b1;
          count_err = 1'b1;
          frame_d   = 1'b0;
        end
      endcase
    end
  end

  logic [63:0]              rxd_q;
  logic [7:0]               rxc_q;
  logic                     rx_valid_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      lock_st_q  <= StUnlocked;
      sh_cnt_q   <= '0;
      inv_cnt_q  <= '0;
      win_cnt_q  <= '0;
      wait_cnt_q <= '0;
      slip_q     <= 1'b0;
      frame_q    <= 1'b0;
      rxd_q      <= ErrRxd;
      rxc_q      <= 8'hFF;
      rx_valid_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      lock_st_q  <= lock_st_d;
      sh_cnt_q   <= sh_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      win_cnt_q  <= win_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      slip_q     <= slip_d;
      rx_valid_q <= rx_block_valid;
      if (rx_block_valid) begin
        frame_q <= frame_d;
        rxd_q   <= out_err ? ErrRxd : dec_rxd;
        rxc_q   <= out_err ? 8'hFF : dec_rxc;
        if (count_err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign rxd         = rxd_q;
  assign rxc         = rxc_q;
  assign rx_valid    = rx_valid_q;
  assign slip        = slip_q;
  assign dec_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_pcs_rx_decoder.sv
module tb_pcs_rx_decoder;

  localparam int CW = 6;  // narrow error counter so saturation is reached

  logic          clk = 1'b0;
  logic          rst_n;
  logic [65:0]   blk;
  logic          bv;
  logic [63:0]   rxd;
  logic [7:0]    rxc;
  logic          rx_valid, block_lock, slip, hi_ber;
  logic [CW-1:0] dec_err_cnt;

  always #5 clk = ~clk;

  pcs_rx_decoder #(.ERR_CNT_WIDTH(CW)) dut (
    .rx_clk        (clk),
    .rx_rst_n      (rst_n),
    .rx_block      (blk),
    .rx_block_valid(bv),
    .rxd           (rxd),
    .rxc           (rxc),
    .rx_valid      (rx_valid),
    .block_lock    (block_lock),
    .slip          (slip),
    .hi_ber        (hi_ber),
    .dec_err_cnt   (dec_err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [63:0] m_rxd   = {8{8'hFE}};
  logic [7:0]  m_rxc   = 8'hFF;
  bit          m_rxv   = 0;
  bit          m_lock  = 0;
  bit          m_slip  = 0;
  bit          m_frame = 0;
  bit          m_hi    = 0;
  int          m_cnt   = 0;
  int          m_run   = 0;
  int          m_hold  = 0;
  int          m_win   = 0;
  int          m_inv   = 0;
  int          m_bn    = 0;
  int          m_bi    = 0;

  logic [7:0] term_btf [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input logic [65:0] b, input logic v);
    logic [1:0]  h   = b[1:0];
    logic [7:0]  btf = b[9:2];
    logic [55:0] p   = b[65:10];
    bit          hv  = (h == 2'b01) || (h == 2'b10);
    logic [7:0]  o[8];
    logic [7:0]  c;
    logic [6:0]  chr;
    int          kind;  // 0 err, 1 data, 2 idle/ordered, 3 start, 4 terminate
    bit          err, counted;
    m_slip = 0;
    m_rxv  = v;
    if (!v) return;
    kind = 0;
    c    = 8'hFF;
    for (int k = 0; k < 8; k++) o[k] = 8'hFE;
    if (h == 2'b10) begin
      kind = 1;
      c    = 8'h00;
      for (int k = 0; k < 8; k++) o[k] = b[2+8*k+:8];
    end else if (h == 2'b01) begin
      if (btf == 8'h1E) begin
        kind = 2;
        for (int k = 0; k < 8; k++) begin
          chr = p[7*k+:7];
          if (chr == 7'h00)      o[k] = 8'h07;
          else if (chr == 7'h06) o[k] = 8'h06;
          else if (chr == 7'h1E) o[k] = 8'hFE;
          else                   kind = 0;
        end
      end else if (btf == 8'h78) begin
        kind = 3;
        c    = 8'h01;
        o[0] = 8'hFB;
        for (int k = 1; k < 8; k++) o[k] = p[8*(k-1)+:8];
      end else begin
        for (int n = 0; n < 8; n++) begin
          if (btf == term_btf[n]) begin
            kind = 4;
            for (int k = 0; k < 8; k++) begin
              if (k < n) begin
                o[k] = p[8*k+:8];
                c[k] = 1'b0;
              end else if (k == n) begin
                o[k] = 8'hFD;
              end else begin
                o[k] = 8'h07;
              end
            end
          end
        end
      end
    end
    err     = 0;
    counted = 1;
    if (!m_lock) begin
      err     = 1;
      counted = 0;
    end else if (m_hi) begin
      err = 1;
    end else begin
      case (kind)
        0: err = 1;
        1: err = !m_frame;
        2: err = m_frame;
        4: err = !m_frame;
        default: err = 0;
      endcase
    end
    if (err) m_frame = 0;
    else if (kind == 3) m_frame = 1;
    else if (kind == 4) m_frame = 0;
    if (err) begin
      for (int k = 0; k < 8; k++) o[k] = 8'hFE;
      c = 8'hFF;
      if (counted && m_cnt < (1 << CW) - 1) m_cnt++;
    end
    for (int k = 0; k < 8; k++) m_rxd[8*k+:8] = o[k];
    m_rxc = c;
`ifdef PCS_BER_MON_EN
    if (m_lock) begin
      m_bn++;
      if (!hv) m_bi++;
      if (m_bi >= 16) m_hi = 1;
      if (m_bn == 1250) begin
        if (m_bi < 16) m_hi = 0;
        m_bn = 0;
        m_bi = 0;
      end
    end
`endif
    if (!m_lock) begin
      if (m_hold > 0) begin
        m_hold--;
      end else if (hv) begin
        m_run++;
        if (m_run == 64) begin
          m_lock = 1;
          m_run  = 0;
          m_win  = 0;
          m_inv  = 0;
        end
      end else begin
        m_slip = 1;
        m_run  = 0;
        m_hold = 4;
      end
    end else begin
      m_win++;
      if (!hv) m_inv++;
      if (m_inv == 16) begin
        m_lock = 0;
        m_slip = 1;
        m_hold = 4;
        m_win  = 0;
        m_inv  = 0;
      end else if (m_win == 64) begin
        m_win = 0;
        m_inv = 0;
      end
    end
  endfunction

  task automatic step(input logic [65:0] b, input logic v);
    @(negedge clk);
    blk = b;
    bv  = v;
    model_step(b, v);
    @(posedge clk);
    #1;
    check("rxd", rxd, m_rxd);
    check("rxc", 64'(rxc), 64'(m_rxc));
    check("rx_valid", 64'(rx_valid), 64'(m_rxv));
    check("block_lock", 64'(block_lock), 64'(m_lock));
    check("slip", 64'(slip), 64'(m_slip));
    check("hi_ber", 64'(hi_ber), 64'(m_hi));
    check("dec_err_cnt", 64'(dec_err_cnt), 64'(m_cnt));
  endtask

  function automatic logic [65:0] mk_data(input logic [63:0] d);
    return {d, 2'b10};
  endfunction

  function automatic logic [65:0] mk_ctrl(input logic [7:0] t, input logic [55:0] p);
    return {p, t, 2'b01};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [65:0] rnd_block();
    int          r = $urandom_range(0, 99);
    logic [63:0] d = rnd64();
    logic [55:0] p = d[55:0];
    if (r < 25) return mk_data(d);
    if (r < 40) return mk_ctrl(8'h78, p);
    if (r < 55) return mk_ctrl(term_btf[$urandom_range(0, 7)], p);
    if (r < 75) begin
      for (int k = 0; k < 8; k++) begin
        case ($urandom_range(0, 2))
          0:       p[7*k+:7] = 7'h00;
          1:       p[7*k+:7] = 7'h06;
          default: p[7*k+:7] = 7'h1E;
        endcase
      end
      return mk_ctrl(8'h1E, p);
    end
    if (r < 80) return mk_ctrl(8'h1E, p);
    if (r < 83) return mk_ctrl(8'($urandom), p);
    if (r < 84) return {d, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00};
    return mk_data(d);
  endfunction

  logic [65:0] idle_blk;

  initial begin
    idle_blk = mk_ctrl(8'h1E, 56'h0);
    rst_n = 1'b0;
    blk   = '0;
    bv    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rxd", rxd, {8{8'hFE}});
    check("reset_rxc", 64'(rxc), 64'hFF);
    check("reset_rx_valid", 64'(rx_valid), 64'd0);
    check("reset_lock", 64'(block_lock), 64'd0);
    check("reset_slip", 64'(slip), 64'd0);
    check("reset_hi_ber", 64'(hi_ber), 64'd0);
    check("reset_err_cnt", 64'(dec_err_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Acquire lock: 64 valid headers with an idle cycle in the middle
    for (int i = 0; i < 64; i++) begin
      if (i == 30) step(mk_data(rnd64()), 1'b0);
      step(mk_data(rnd64()), 1'b1);
    end
    check("lock_after_64", 64'(block_lock), 64'd1);
    step(mk_data(rnd64()), 1'b0);
    check("rx_valid_gap", 64'(rx_valid), 64'd0);

    // Data without start, then bad ordered-set character
    step(mk_data(64'h1122334455667788), 1'b1);
    check("orphan_data_rxc", 64'(rxc), 64'hFF);
    check("orphan_data_cnt", 64'(dec_err_cnt), 64'd1);
    step(mk_ctrl(8'h1E, {49'h0, 7'h55}), 1'b1);
    check("bad_char_rxd", rxd, {8{8'hFE}});
    check("bad_char_cnt", 64'(dec_err_cnt), 64'd2);

    // Frame: start, two data, terminate with 2 octets
    step(mk_ctrl(8'h78, 56'h07060504030201), 1'b1);
    check("start_rxc", 64'(rxc), 64'h01);
    check("start_rxd", rxd, 64'h07060504030201FB);
    step(mk_data(64'hDEADBEEFCAFEF00D), 1'b1);
    check("data1_rxc", 64'(rxc), 64'h00);
    step(mk_data(64'h0123456789ABCDEF), 1'b1);
    check("data2_rxd", rxd, 64'h0123456789ABCDEF);
    step(mk_ctrl(8'hAA, 56'h7F7F7F7F7FBBAA), 1'b1);
    check("term_rxc", 64'(rxc), 64'hFC);
    check("term_rxd", rxd, 64'h0707070707FDBBAA);

    // 15 invalid headers in one lock window keep lock
    for (int i = 0; i < 70 && m_win != 0; i++) step(idle_blk, 1'b1);
    for (int i = 0; i < 15; i++) step({rnd64(), 2'b00}, 1'b1);
    check("lock_15_invalid", 64'(block_lock), 64'd1);
    // 16 in one window drop lock and slip on the 16th
    for (int i = 0; i < 70 && m_win != 0; i++) step(idle_blk, 1'b1);
    for (int i = 0; i < 16; i++) step({rnd64(), 2'b00}, 1'b1);
    check("drop_lock_16", 64'(block_lock), 64'd0);
    check("drop_slip_16", 64'(slip), 64'd1);
`ifdef PCS_BER_MON_EN
    check("hi_ber_set", 64'(hi_ber), 64'd1);
`endif

    // Hold-off: invalid headers ignored for 4 blocks
    for (int i = 0; i < 4; i++) step({rnd64(), 2'b11}, 1'b1);
    check("holdoff_no_slip", 64'(slip), 64'd0);
    step({rnd64(), 2'b11}, 1'b1);
    check("unlocked_slip", 64'(slip), 64'd1);
    step(mk_data(rnd64()), 1'b1);
    check("slip_one_cycle", 64'(slip), 64'd0);
    for (int i = 0; i < 3; i++) step({rnd64(), 2'b11}, 1'b1);
    for (int i = 0; i < 63; i++) step(mk_data(rnd64()), 1'b1);
    check("relock_63", 64'(block_lock), 64'd0);
    step(mk_data(rnd64()), 1'b1);
    check("relock_64", 64'(block_lock), 64'd1);

`ifdef PCS_BER_MON_EN
    for (int i = 0; i < 2600; i++) step(idle_blk, 1'b1);
    check("hi_ber_clear", 64'(hi_ber), 64'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) step(rnd_block(), ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
